// File: rtl/enc8to3_pend_if.sv
// Request/selection bundle between an event source, the pending encoder and
// the consumer of its binary index stream.
interface enc8to3_pend_if #(
  parameter int N_IN  = 8,
  parameter int W_IDX = 3
);
  logic [N_IN-1:0]  req_in;
  logic [N_IN-1:0]  mask;
  logic             out_ready;
  logic             out_valid;
  logic [W_IDX-1:0] out_idx;
  logic [N_IN-1:0]  out_onehot;
  logic [N_IN-1:0]  pending;
  logic             overflow;

  modport master (
    output req_in, mask, out_ready,
    input  out_valid, out_idx, out_onehot, pending, overflow
  );

  modport slave (
    input  req_in, mask, out_ready,
    output out_valid, out_idx, out_onehot, pending, overflow
  );
endinterface

// File: rtl/enc8to3_pend.sv
// Sticky pending encoder: request lines accumulate in a pending register and
// are streamed out as binary indices, one per accepted valid/ready handshake.
//
// state   | meaning
// IDLE    | nothing presented, out_valid=0, out_onehot=0
// PRESENT | out_idx/out_onehot held stable until out_ready
module enc8to3_pend #(
  parameter int N_IN      = 8,
  parameter int W_IDX     = 3,
  parameter bit PRIO_HIGH = 1'b1
) (
  input logic           clk,
  input logic           rst,
  enc8to3_pend_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [N_IN-1:0] ONE = N_IN'(1);

  state_t           state;
  logic             out_valid_q;
  logic [W_IDX-1:0] out_idx_q;
  logic [N_IN-1:0]  out_onehot_q;
  logic [N_IN-1:0]  pending_q;
  logic             overflow_q;

  logic             accept;
  logic [N_IN-1:0]  clr;
  logic [N_IN-1:0]  elig;
  logic             sel_found;
  logic [W_IDX-1:0] sel_idx;

  assign accept = out_valid_q & bus.out_ready;
  assign clr    = accept ? out_onehot_q : '0;
  // Excluding clr covers both cases: in IDLE out_onehot is zero anyway.
  assign elig   = pending_q & ~bus.mask & ~clr;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < N_IN; i++) begin
        if (elig[i]) begin
          sel_found = 1'b1;
          sel_idx   = W_IDX'(i);
        end
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (elig[i]) begin
          sel_found = 1'b1;
          sel_idx   = W_IDX'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pending_q  <= (pending_q & ~clr) | bus.req_in;
      overflow_q <= |(bus.req_in & pending_q & ~clr);
      case (state)
        IDLE: begin
          if (sel_found) begin
            state        <= PRESENT;
            out_valid_q  <= 1'b1;
            out_idx_q    <= sel_idx;
            out_onehot_q <= ONE << sel_idx;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            if (sel_found) begin
              out_idx_q    <= sel_idx;
              out_onehot_q <= ONE << sel_idx;
            end else begin
              // out_idx keeps the last accepted value.
              state        <= IDLE;
              out_valid_q  <= 1'b0;
              out_onehot_q <= '0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          out_valid_q  <= 1'b0;
          out_onehot_q <= '0;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_enc8to3_pend.sv
// Bench for enc8to3_pend: a highest-first and a lowest-first instance share
// stimulus and are compared every cycle against a set-based reference model.
module tb_enc8to3_pend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] msk = 8'h00;
  logic       rdy = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  enc8to3_pend_if #(.N_IN(8), .W_IDX(3)) if0 ();
  enc8to3_pend_if #(.N_IN(8), .W_IDX(3)) if1 ();

  assign if0.req_in    = req;
  assign if0.mask      = msk;
  assign if0.out_ready = rdy;
  assign if1.req_in    = req;
  assign if1.mask      = msk;
  assign if1.out_ready = rdy;

  enc8to3_pend #(.N_IN(8), .W_IDX(3), .PRIO_HIGH(1'b1)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  enc8to3_pend #(.N_IN(8), .W_IDX(3), .PRIO_HIGH(1'b0)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending set, the presented line (if any) and the last
  // presented index, advanced once per clock from the sampled inputs.
  logic [7:0] m_pend [2];
  bit         m_val  [2];
  int         m_idx  [2];
  bit         m_ovf  [2];
  bit         live = 1'b0;
  logic [7:0] m_clr, m_cand;

  function automatic int pick(input logic [7:0] c, input bit highest);
    int r = -1;
    for (int i = 0; i < 8; i++)
      if (c[i] && (highest || r < 0)) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pend[d] = 8'h00;
        m_val[d]  = 1'b0;
        m_idx[d]  = 0;
        m_ovf[d]  = 1'b0;
      end else begin
        m_clr  = (m_val[d] && rdy) ? (8'h01 << m_idx[d]) : 8'h00;
        m_ovf[d] = (req & m_pend[d] & ~m_clr) != 8'h00;
        m_cand = m_pend[d] & ~msk & ~m_clr;
        if (!m_val[d] || rdy) begin
          if (m_cand != 8'h00) begin
            m_val[d] = 1'b1;
            m_idx[d] = pick(m_cand, d == 0);
          end else begin
            m_val[d] = 1'b0;
          end
        end
        m_pend[d] = (m_pend[d] & ~m_clr) | req;
      end
    end
    if (rst) live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("hi_valid",   32'(if0.out_valid),  32'(m_val[0]));
      chk("hi_idx",     32'(if0.out_idx),    32'(m_idx[0]));
      chk("hi_onehot",  32'(if0.out_onehot), m_val[0] ? (32'h1 << m_idx[0]) : 32'h0);
      chk("hi_pending", 32'(if0.pending),    32'(m_pend[0]));
      chk("hi_ovf",     32'(if0.overflow),   32'(m_ovf[0]));
      chk("lo_valid",   32'(if1.out_valid),  32'(m_val[1]));
      chk("lo_idx",     32'(if1.out_idx),    32'(m_idx[1]));
      chk("lo_onehot",  32'(if1.out_onehot), m_val[1] ? (32'h1 << m_idx[1]) : 32'h0);
      chk("lo_pending", 32'(if1.pending),    32'(m_pend[1]));
      chk("lo_ovf",     32'(if1.overflow),   32'(m_ovf[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;

    // Reset with a request present: it must be ignored.
    req = 8'hFF;
    tick();
    tick();
    req = 8'h00;
    chk("rst_valid",   32'(if0.out_valid),  32'h0);
    chk("rst_idx",     32'(if0.out_idx),    32'h0);
    chk("rst_onehot",  32'(if0.out_onehot), 32'h0);
    chk("rst_pending", 32'(if0.pending),    32'h0);
    rst = 1'b0;
    tick();
    chk("rst_req_ignored", 32'(if0.pending), 32'h0);

    // Highest-first drains 0x24 as 5 then 2.
    rdy = 1'b1;
    req = 8'h24;
    tick();
    req = 8'h00;
    chk("t1_pend", 32'(if0.pending), 32'h24);
    tick();
    chk("t1_v5",  32'(if0.out_valid),  32'h1);
    chk("t1_i5",  32'(if0.out_idx),    32'h5);
    chk("t1_oh5", 32'(if0.out_onehot), 32'h20);
    tick();
    chk("t1_i2",  32'(if0.out_idx),    32'h2);
    chk("t1_oh2", 32'(if0.out_onehot), 32'h04);
    tick();
    chk("t1_v0",   32'(if0.out_valid), 32'h0);
    chk("t1_pend0", 32'(if0.pending),  32'h00);

    // Stall holds idx 0 even after line 7 arrives.
    rdy = 1'b0;
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    tick();
    chk("t2_hold", 32'(if0.out_idx), 32'h0);
    chk("t2_pend", 32'(if0.pending), 32'h81);
    rdy = 1'b1;
    tick();
    chk("t2_i7", 32'(if0.out_idx), 32'h7);
    tick();
    chk("t2_v0",   32'(if0.out_valid), 32'h0);
    chk("t2_pend0", 32'(if0.pending),  32'h00);

    // Overflow on a repeated request to a pending line.
    rdy = 1'b0;
    req = 8'h08;
    tick();
    chk("t3_ovf_first", 32'(if0.overflow), 32'h0);
    tick();
    req = 8'h00;
    chk("t3_ovf", 32'(if0.overflow), 32'h1);
    tick();
    chk("t3_ovf_gone", 32'(if0.overflow), 32'h0);
    chk("t3_pend",     32'(if0.pending),  32'h08);
    chk("t3_present3", 32'(if0.out_idx),  32'h3);

    // Re-request on the line being accepted: no overflow, re-presented.
    rdy = 1'b1;
    req = 8'h08;
    tick();
    req = 8'h00;
    chk("t5_ovf",   32'(if0.overflow),  32'h0);
    chk("t5_pend",  32'(if0.pending),   32'h08);
    chk("t5_v0",    32'(if0.out_valid), 32'h0);
    tick();
    chk("t5_v1",    32'(if0.out_valid), 32'h1);
    chk("t5_i3",    32'(if0.out_idx),   32'h3);
    tick();

    // All lines masked: accumulate only.
    msk = 8'hFF;
    req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("t4_v0",   32'(if0.out_valid), 32'h0);
    chk("t4_pend", 32'(if0.pending),   32'h10);
    msk = 8'h00;
    tick();
    chk("t4_v1", 32'(if0.out_valid), 32'h1);
    chk("t4_i4", 32'(if0.out_idx),   32'h4);
    tick();

    // Lowest-first: reset mid-stall, then 0x66 drains as 1,2,5,6.
    rdy = 1'b0;
    req = 8'h66;
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("t6_pre_pend", 32'(if1.pending), 32'h66);
    chk("t6_pre_idx",  32'(if1.out_idx), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_v",   32'(if1.out_valid),  32'h0);
    chk("t6_rst_p",   32'(if1.pending),    32'h0);
    chk("t6_rst_oh",  32'(if1.out_onehot), 32'h0);
    rdy = 1'b1;
    req = 8'h66;
    tick();
    req = 8'h00;
    tick();
    chk("t6_i1", 32'(if1.out_idx), 32'h1);
    tick();
    chk("t6_i2", 32'(if1.out_idx), 32'h2);
    tick();
    chk("t6_i5", 32'(if1.out_idx), 32'h5);
    tick();
    chk("t6_i6", 32'(if1.out_idx), 32'h6);
    tick();
    chk("t6_v0", 32'(if1.out_valid), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      req = ($urandom_range(0, 3) == 0) ? r[7:0] : 8'h00;
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom;
        msk = ($urandom_range(0, 1) == 0) ? 8'h00 : r[7:0];
      end
      rdy = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    req = 8'h00;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
